// File: rtl/enc_con_sequencer_pkg.sv
// Shared encoder definitions for the RS encoder datapath.
// Holds the code geometry (symbols per beat, codeword and message length),
// the beat counts derived from it, the phase enum and the per-beat tag
// that travels alongside the datapath.
package enc_con_sequencer_pkg;

    localparam int ENC_SYM         = 4;
    localparam int ENC_N           = 256;
    localparam int ENC_K           = 240;
    localparam int ENC_MES_BUF_DEP = 16;

    localparam int ENC_MES_BEATS = ENC_K / ENC_SYM;
    localparam int ENC_PAR_BEATS = (ENC_N - ENC_K) / ENC_SYM;
    localparam int ENC_LAT       = ENC_MES_BUF_DEP / ENC_SYM;

    typedef enum logic {
        ENC_PH_MES = 1'b0,
        ENC_PH_PAR = 1'b1
    } enc_phase_e;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
        logic par;
    } enc_tag_t;

    // Beat counter width; never narrower than one bit so a one-beat phase
    // still has a legal register.
    function automatic int enc_cnt_width(input int mes_beats, input int par_beats);
        int max_beats;
        max_beats = (mes_beats > par_beats) ? mes_beats : par_beats;
        return (max_beats > 1) ? $clog2(max_beats) : 1;
    endfunction

endpackage

// File: rtl/enc_con_sequencer_if.sv
// Handshake and control bundle around the codeword sequencer.
//   gen_valid / gen_ready : message beats from the input generator
//   out_ready             : downstream sink backpressure
//   con_stall/phase/first : datapath control (buffer, LFSR, output reg)
//   out_valid/sop/eop/par : tags aligned with the datapath output beat
// master = sequencer side, slave = generator/datapath/sink side.
interface enc_con_sequencer_if;

    logic gen_valid;
    logic gen_ready;
    logic out_ready;
    logic con_stall;
    logic con_phase;
    logic con_first;
    logic out_valid;
    logic out_sop;
    logic out_eop;
    logic out_par;

    modport master (
        input  gen_valid,
        input  out_ready,
        output gen_ready,
        output con_stall,
        output con_phase,
        output con_first,
        output out_valid,
        output out_sop,
        output out_eop,
        output out_par
    );

    modport slave (
        output gen_valid,
        output out_ready,
        input  gen_ready,
        input  con_stall,
        input  con_phase,
        input  con_first,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        input  out_par
    );

endinterface

// File: rtl/enc_con_sequencer_tag_pipe.sv
// Tag delay line matching the encoder datapath latency.
// DEPTH stages of enc_tag_t that shift only when en is high, so the tag
// leaving the last stage belongs to the datapath beat leaving the output
// register. All stages clear to zero on reset.
// Ports: clk, rst_n, en (shift enable), tag_in (stage 0 load),
//        tag_out (last stage).
module enc_con_sequencer_tag_pipe
    import enc_con_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  enc_tag_t tag_in,
    output enc_tag_t tag_out
);

    enc_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/enc_con_sequencer.sv
// Codeword sequencer for the RS encoder datapath.
// Accepts ENC_MES_BEATS message beats per codeword from the generator,
// then runs ENC_PAR_BEATS parity beats with the generator held off, and
// tags the output stream with sop/eop/par delayed by ENC_LAT advancing
// beats. con_stall freezes the whole datapath whenever the sink holds the
// output or the generator pauses mid-codeword.
// Ports: clk, rst_n (async, active low), bus (enc_con_sequencer_if.master).
//
// state      | meaning
// -----------+--------------------------------------------------------
// ENC_PH_MES | accepting message beats; cnt = index of next message beat
// ENC_PH_PAR | emitting parity beats;   cnt = index of next parity beat
module enc_con_sequencer
    import enc_con_sequencer_pkg::*;
#(
    parameter int ENC_MES_BEATS = enc_con_sequencer_pkg::ENC_MES_BEATS,
    parameter int ENC_PAR_BEATS = enc_con_sequencer_pkg::ENC_PAR_BEATS,
    parameter int ENC_LAT       = enc_con_sequencer_pkg::ENC_LAT
) (
    input logic                 clk,
    input logic                 rst_n,
    enc_con_sequencer_if.master bus
);

    localparam int CNT_W = enc_cnt_width(ENC_MES_BEATS, ENC_PAR_BEATS);
    localparam logic [CNT_W-1:0] MES_LAST = CNT_W'(ENC_MES_BEATS - 1);
    localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(ENC_PAR_BEATS - 1);

    enc_phase_e       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic     hold;
    logic     cnt_zero;
    logic     gen_ready;
    logic     real_beat;
    logic     advance;
    logic     accept;
    logic     first;
    enc_tag_t tag_in;
    enc_tag_t tag_out;

    // The sink holding a valid output beat freezes everything upstream.
    assign hold     = tag_out.valid && !bus.out_ready;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= ENC_PH_MES;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        gen_ready = 1'b0;
        real_beat = 1'b0;
        advance   = 1'b0;
        unique case (phase_q)
            ENC_PH_MES: begin
                gen_ready = !hold;
                real_beat = bus.gen_valid;
                // At a codeword boundary an empty generator still advances,
                // pushing a bubble so the previous codeword drains out.
                // Mid-codeword an empty generator stalls the datapath.
                advance   = !hold && (bus.gen_valid || cnt_zero);
                if (advance && real_beat) begin
                    if (cnt_q == MES_LAST) begin
                        phase_d = ENC_PH_PAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ENC_PH_PAR: begin
                real_beat = 1'b1;
                advance   = !hold;
                if (advance) begin
                    if (cnt_q == PAR_LAST) begin
                        phase_d = ENC_PH_MES;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    assign accept = bus.gen_valid && gen_ready;
    assign first  = (phase_q == ENC_PH_MES) && cnt_zero && accept;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = real_beat;
        tag_in.sop   = first;
        tag_in.eop   = (phase_q == ENC_PH_PAR) && (cnt_q == PAR_LAST);
        tag_in.par   = (phase_q == ENC_PH_PAR);
    end

    enc_con_sequencer_tag_pipe #(
        .DEPTH (ENC_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bus.gen_ready = gen_ready;
    assign bus.con_stall = !advance;
    assign bus.con_phase = (phase_q == ENC_PH_PAR);
    assign bus.con_first = first;
    assign bus.out_valid = tag_out.valid;
    assign bus.out_sop   = tag_out.sop;
    assign bus.out_eop   = tag_out.eop;
    assign bus.out_par   = tag_out.par;

endmodule

// File: tb/tb_enc_con_sequencer.sv
module tb_enc_con_sequencer;

    localparam int M = 4;
    localparam int P = 2;
    localparam int L = 2;

    typedef struct packed {
        logic sop;
        logic eop;
        logic par;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    exp_t sb_q [$];
    int   mes_idx;
    int   cw_beats;
    int   cw_par;

    enc_con_sequencer_if bus ();

    enc_con_sequencer #(
        .ENC_MES_BEATS (M),
        .ENC_PAR_BEATS (P),
        .ENC_LAT       (L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the active edge, return at the
    // following falling edge where outputs are sampled.
    task automatic drive(input logic gv, input logic ordy);
        @(posedge clk);
        #1;
        bus.gen_valid = gv;
        bus.out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b1);
        end
    endtask

    // Reference model: every accepted message beat adds its tag to the
    // expected output stream; completing a message adds the parity beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            mes_idx  = 0;
            cw_beats = 0;
            cw_par   = 0;
        end else begin
            if (bus.gen_valid && bus.gen_ready) begin
                chk("con_first", bus.con_first, (mes_idx == 0));
                sb_q.push_back('{sop: (mes_idx == 0), eop: 1'b0, par: 1'b0});
                mes_idx++;
                if (mes_idx == M) begin
                    mes_idx = 0;
                    for (int p = 0; p < P; p++) begin
                        sb_q.push_back('{sop: 1'b0, eop: (p == P - 1), par: 1'b1});
                    end
                end
            end else begin
                chk("con_first_idle", bus.con_first, 0);
            end
            if (bus.out_valid && !bus.out_ready) begin
                chk("hold_con_stall", bus.con_stall, 1);
                chk("hold_gen_ready", bus.gen_ready, 0);
            end
            if (bus.out_valid && bus.out_ready && !bus.con_stall) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_beat: got sop=%0b eop=%0b par=%0b expected no beat at %0t",
                             bus.out_sop, bus.out_eop, bus.out_par, $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_tags", {29'd0, bus.out_sop, bus.out_eop, bus.out_par},
                        {29'd0, e.sop, e.eop, e.par});
                end
                if (bus.out_sop) begin
                    cw_beats = 0;
                    cw_par   = 0;
                end
                cw_beats++;
                if (bus.out_par) cw_par++;
                if (bus.out_eop) begin
                    chk("cw_len", cw_beats, M + P);
                    chk("cw_par_beats", cw_par, P);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.gen_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_tags", {bus.out_sop, bus.out_eop, bus.out_par}, 0);
        chk("rst_gen_ready", bus.gen_ready, 1);
        chk("rst_con_phase", bus.con_phase, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Continuous traffic: two back-to-back codewords.
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, 1'b1);
            chk("s1_gen_ready", bus.gen_ready, (((i - 1) % 6) < 4));
            chk("s1_con_phase", bus.con_phase, (((i - 1) % 6) >= 4));
            chk("s1_con_first", bus.con_first, (((i - 1) % 6) == 0));
            chk("s1_con_stall", bus.con_stall, 0);
            chk("s1_out_valid", bus.out_valid, (i >= 3));
            chk("s1_out_sop", bus.out_sop, (i == 3 || i == 9));
            chk("s1_out_par", bus.out_par, (i == 7 || i == 8));
            chk("s1_out_eop", bus.out_eop, (i == 8));
        end

        // Generator goes quiet at a boundary: bubbles drain the pipeline.
        found = 0;
        for (int j = 1; j <= L; j++) begin
            drive(1'b0, 1'b1);
            chk("s3_con_stall", bus.con_stall, 0);
            if (bus.out_eop) found = 1;
        end
        chk("s3_eop_seen", found, 1);
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, 1'b1);
            chk("s3_out_valid", bus.out_valid, 0);
            chk("s3_con_stall", bus.con_stall, 0);
        end

        // Mid-codeword gap stalls everything.
        repeat (2) drive(1'b1, 1'b1);
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b1);
            chk("s2_con_stall", bus.con_stall, 1);
            chk("s2_gen_ready", bus.gen_ready, 1);
            chk("s2_con_phase", bus.con_phase, 0);
        end
        repeat (2) drive(1'b1, 1'b1);
        drain(8);

        // Sink backpressure during parity.
        repeat (M) drive(1'b1, 1'b1);
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b0);
            chk("s4_con_stall", bus.con_stall, 1);
            chk("s4_gen_ready", bus.gen_ready, 0);
            chk("s4_con_phase", bus.con_phase, 1);
            chk("s4_out_valid", bus.out_valid, 1);
            chk("s4_out_sop", bus.out_sop, 0);
        end
        drain(8);

        // Reset at message beat 3 of the second codeword.
        repeat (M + P + 3) drive(1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.gen_valid = 1'b0;
        #1;
        chk("s5_out_valid", bus.out_valid, 0);
        chk("s5_out_tags", {bus.out_sop, bus.out_eop, bus.out_par}, 0);
        chk("s5_con_phase", bus.con_phase, 0);
        chk("s5_gen_ready", bus.gen_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * M) drive(1'b1, 1'b1);
        drain(8);

        // Random traffic.
        for (int c = 0; c < 1000; c++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 200 && mes_idx != 0; k++) begin
            drive(1'b1, 1'b1);
        end
        chk("s6_boundary_reached", mes_idx, 0);
        drain(12);
        chk("s6_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
